// File: rtl/cc_rowcomp_pkg.sv
// Shared types and pattern constants for the row compositor.
package cc_rowcomp_pkg;

    // Frame command modes; codes 6 and 7 fall back to SPRITE.
    typedef enum logic [2:0] {
        MODE_CLEAR       = 3'd0,
        MODE_PASS        = 3'd1,
        MODE_SCROLL      = 3'd2,
        MODE_WALL        = 3'd3,
        MODE_SPRITE      = 3'd4,
        MODE_SCROLL_WRAP = 3'd5
    } mode_t;

    // Compositor control state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SCROLL = 1'b1
    } state_t;

    // Pattern rows, element 0 is the top row of the frame.
    localparam int WALL_ROWS   = 4;
    localparam int SPRITE_ROWS = 7;

    localparam logic [7:0] WALL_PAT [WALL_ROWS] = '{
        8'hF0, 8'hF0, 8'hF0, 8'hF0
    };

    localparam logic [7:0] SPRITE_PAT [SPRITE_ROWS] = '{
        8'h42, 8'h3C, 8'h3C, 8'h42, 8'h66, 8'h00, 8'h00
    };

endpackage

// File: rtl/cc_row_compositor_if.sv
// Command/frame bundle between game logic, the compositor and the scan driver.
// Handshake: load, tick and abort are single-cycle strobes sampled on the
// rising clock edge; there is no ready path, the compositor drops loads that
// arrive while busy. done is a one-cycle completion pulse, frame/busy/done
// are registered.
interface cc_row_compositor_if #(
    parameter int ROWS  = 7,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(ROWS + 1)
);
    import cc_rowcomp_pkg::*;

    logic [2:0]            CC_ROWCOMP_mode_InBUS;
    logic                  CC_ROWCOMP_load_In;
    logic                  CC_ROWCOMP_tick_In;
    logic                  CC_ROWCOMP_abort_In;
    logic [CW-1:0]         CC_ROWCOMP_shiftCount_InBUS;
    logic [ROWS*WIDTH-1:0] CC_ROWCOMP_data_InBUS;
    logic [ROWS*WIDTH-1:0] CC_ROWCOMP_frame_OutBUS;
    logic                  CC_ROWCOMP_busy_Out;
    logic                  CC_ROWCOMP_done_Out;
    state_t                stateDbg;

    modport master (
        output CC_ROWCOMP_mode_InBUS, CC_ROWCOMP_load_In, CC_ROWCOMP_tick_In,
               CC_ROWCOMP_abort_In, CC_ROWCOMP_shiftCount_InBUS, CC_ROWCOMP_data_InBUS,
        input  CC_ROWCOMP_frame_OutBUS, CC_ROWCOMP_busy_Out, CC_ROWCOMP_done_Out, stateDbg
    );

    modport slave (
        input  CC_ROWCOMP_mode_InBUS, CC_ROWCOMP_load_In, CC_ROWCOMP_tick_In,
               CC_ROWCOMP_abort_In, CC_ROWCOMP_shiftCount_InBUS, CC_ROWCOMP_data_InBUS,
        output CC_ROWCOMP_frame_OutBUS, CC_ROWCOMP_busy_Out, CC_ROWCOMP_done_Out, stateDbg
    );
endinterface

// File: rtl/cc_rowcomp_shifter.sv
// One-row downward shift of a packed frame; the top row is either zero or
// the old bottom row when wrap is set.
module cc_rowcomp_shifter #(
    parameter int ROWS  = 7,
    parameter int WIDTH = 8
) (
    input  logic [ROWS*WIDTH-1:0] frameIn,
    input  logic                  wrap,
    output logic [ROWS*WIDTH-1:0] frameOut
);

    // Each row takes the row above it; the top row is refilled.
    always_comb begin
        frameOut = '0;
        for (int r = 0; r < ROWS - 1; r++) begin
            frameOut[r*WIDTH +: WIDTH] = frameIn[(r+1)*WIDTH +: WIDTH];
        end
        frameOut[(ROWS-1)*WIDTH +: WIDTH] = wrap ? frameIn[0 +: WIDTH] : '0;
    end

endmodule

// File: rtl/cc_row_compositor.sv
// Row-frame compositor: loads blank/pass/pattern frames and scrolls the input
// frame down one row per tick for a programmed number of steps.
module cc_row_compositor
    import cc_rowcomp_pkg::*;
#(
    parameter int ROWS  = 7,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(ROWS + 1)
) (
    input  logic                 CC_ROWCOMP_CLOCK_50,
    input  logic                 CC_ROWCOMP_RESET_InLow,
    cc_row_compositor_if.slave   bus
);

    localparam int FW = ROWS * WIDTH;

    state_t          state;
    logic [FW-1:0]   frameReg;
    logic [FW-1:0]   shiftedFrame;
    logic [FW-1:0]   wallFrame;
    logic [FW-1:0]   spriteFrame;
    logic [CW-1:0]   stepCount;
    logic            scrollWrap;
    logic            busyReg;
    logic            doneReg;
    mode_t           modeSel;

    assign modeSel = mode_t'(bus.CC_ROWCOMP_mode_InBUS);

    // Fixed patterns, placed in the low 8 bits of each row, top row first.
    for (genvar r = 0; r < ROWS; r++) begin : g_pattern
        localparam int TOP_IDX = ROWS - 1 - r;
        if (TOP_IDX < WALL_ROWS) begin : g_wall
            assign wallFrame[r*WIDTH +: WIDTH] = WIDTH'(WALL_PAT[TOP_IDX]);
        end else begin : g_wall_zero
            assign wallFrame[r*WIDTH +: WIDTH] = '0;
        end
        if (TOP_IDX < SPRITE_ROWS) begin : g_sprite
            assign spriteFrame[r*WIDTH +: WIDTH] = WIDTH'(SPRITE_PAT[TOP_IDX]);
        end else begin : g_sprite_zero
            assign spriteFrame[r*WIDTH +: WIDTH] = '0;
        end
    end

    cc_rowcomp_shifter #(
        .ROWS  (ROWS),
        .WIDTH (WIDTH)
    ) u_shifter (
        .frameIn  (frameReg),
        .wrap     (scrollWrap),
        .frameOut (shiftedFrame)
    );

    // Command FSM with the step counter, frame register and status flags.
    always_ff @(posedge CC_ROWCOMP_CLOCK_50 or negedge CC_ROWCOMP_RESET_InLow) begin
        if (!CC_ROWCOMP_RESET_InLow) begin
            state      <= ST_IDLE;
            frameReg   <= '0;
            stepCount  <= '0;
            scrollWrap <= 1'b0;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.CC_ROWCOMP_load_In) begin
                        case (modeSel)
                            MODE_CLEAR: begin
                                frameReg <= '0;
                                doneReg  <= 1'b1;
                            end
                            MODE_PASS: begin
                                frameReg <= bus.CC_ROWCOMP_data_InBUS;
                                doneReg  <= 1'b1;
                            end
                            MODE_SCROLL, MODE_SCROLL_WRAP: begin
                                frameReg <= bus.CC_ROWCOMP_data_InBUS;
                                if (bus.CC_ROWCOMP_shiftCount_InBUS == '0) begin
                                    doneReg <= 1'b1;
                                end else begin
                                    state      <= ST_SCROLL;
                                    busyReg    <= 1'b1;
                                    stepCount  <= bus.CC_ROWCOMP_shiftCount_InBUS;
                                    scrollWrap <= (modeSel == MODE_SCROLL_WRAP);
                                end
                            end
                            MODE_WALL: begin
                                frameReg <= wallFrame;
                                doneReg  <= 1'b1;
                            end
                            default: begin
                                frameReg <= spriteFrame;
                                doneReg  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_SCROLL: begin
                    // Abort wins over a coincident tick and leaves the frame as is.
                    if (bus.CC_ROWCOMP_abort_In) begin
                        state   <= ST_IDLE;
                        busyReg <= 1'b0;
                    end else if (bus.CC_ROWCOMP_tick_In) begin
                        frameReg  <= shiftedFrame;
                        stepCount <= stepCount - CW'(1);
                        if (stepCount == CW'(1)) begin
                            state   <= ST_IDLE;
                            busyReg <= 1'b0;
                            doneReg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.CC_ROWCOMP_frame_OutBUS = frameReg;
    assign bus.CC_ROWCOMP_busy_Out     = busyReg;
    assign bus.CC_ROWCOMP_done_Out     = doneReg;
    assign bus.stateDbg                = state;

endmodule

// File: tb/tb_cc_row_compositor.sv
// Directed bench for cc_row_compositor at ROWS=7, WIDTH=8.
module tb_cc_row_compositor;
    import cc_rowcomp_pkg::*;

    localparam int ROWS  = 7;
    localparam int WIDTH = 8;
    localparam int CW    = 3;
    localparam int FW    = ROWS * WIDTH;

    localparam logic [FW-1:0] DATA      = 56'h07060504030201;
    localparam logic [FW-1:0] SPRITE_F  = 56'h423C3C42660000;
    localparam logic [FW-1:0] WALL_F    = 56'hF0F0F0F0000000;
    localparam logic [FW-1:0] SHIFT1    = 56'h00070605040302;
    localparam logic [FW-1:0] SHIFT2    = 56'h00000706050403;
    localparam logic [FW-1:0] WRAP1     = 56'h01070605040302;
    localparam logic [FW-1:0] WRAP3     = 56'h03020107060504;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] exp_frame;

    cc_row_compositor_if #(.ROWS(ROWS), .WIDTH(WIDTH), .CW(CW)) bus ();

    cc_row_compositor #(.ROWS(ROWS), .WIDTH(WIDTH), .CW(CW)) dut (
        .CC_ROWCOMP_CLOCK_50    (clk),
        .CC_ROWCOMP_RESET_InLow (rst_n),
        .bus                    (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // drive one load command; returns at the negedge after the capturing edge
    task automatic drive_load(input logic [2:0] m, input logic [CW-1:0] cnt);
        @(negedge clk);
        bus.CC_ROWCOMP_mode_InBUS       = m;
        bus.CC_ROWCOMP_shiftCount_InBUS = cnt;
        bus.CC_ROWCOMP_load_In          = 1'b1;
        @(negedge clk);
        bus.CC_ROWCOMP_load_In          = 1'b0;
    endtask

    // one tick pulse after idling 'gap' cycles
    task automatic drive_tick(input int gap);
        repeat (gap) @(negedge clk);
        bus.CC_ROWCOMP_tick_In = 1'b1;
        @(negedge clk);
        bus.CC_ROWCOMP_tick_In = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        exp_frame = exp_q.pop_front();
        chk(tag, 64'(bus.CC_ROWCOMP_frame_OutBUS), 64'(exp_frame));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        bus.CC_ROWCOMP_mode_InBUS       = 3'd0;
        bus.CC_ROWCOMP_load_In          = 1'b0;
        bus.CC_ROWCOMP_tick_In          = 1'b0;
        bus.CC_ROWCOMP_abort_In         = 1'b0;
        bus.CC_ROWCOMP_shiftCount_InBUS = '0;
        bus.CC_ROWCOMP_data_InBUS       = DATA;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_frame", 64'(bus.CC_ROWCOMP_frame_OutBUS), 64'h0);
        chk("rst_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);
        chk("rst_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // PASS
        exp_q.push_back(DATA);
        drive_load(3'd1, '0);
        check_frame("pass_frame");
        chk("pass_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        chk("pass_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);
        @(negedge clk);
        chk("pass_done_drop", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);

        // patterns, back-to-back loads each pulse done
        exp_q.push_back(SPRITE_F);
        drive_load(3'd4, '0);
        check_frame("sprite_frame");
        chk("sprite_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        exp_q.push_back(WALL_F);
        drive_load(3'd3, '0);
        check_frame("wall_frame");
        chk("wall_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        exp_q.push_back(SPRITE_F);
        drive_load(3'd7, '0);
        check_frame("mode7_frame");
        exp_q.push_back(SPRITE_F);
        drive_load(3'd6, '0);
        check_frame("mode6_frame");

        // SCROLL by 2, ticks every 5 cycles
        exp_q.push_back(DATA);
        drive_load(3'd2, 3'd2);
        check_frame("scr_load_frame");
        chk("scr_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h1);
        chk("scr_no_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        exp_q.push_back(SHIFT1);
        drive_tick(4);
        check_frame("scr_tick1");
        chk("scr_tick1_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h1);
        chk("scr_tick1_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        exp_q.push_back(SHIFT2);
        drive_tick(4);
        check_frame("scr_tick2");
        chk("scr_tick2_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);
        chk("scr_tick2_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        @(negedge clk);
        chk("scr_done_drop", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);

        // SCROLL_WRAP by 7 with a load issued mid-scroll
        exp_q.push_back(DATA);
        drive_load(3'd5, 3'd7);
        check_frame("wrap_load");
        exp_q.push_back(WRAP1);
        drive_tick(4);
        check_frame("wrap_tick1");
        drive_tick(4);
        drive_tick(4);
        exp_q.push_back(WRAP3);
        drive_load(3'd0, '0);
        check_frame("wrap_load_ignored");
        chk("wrap_ign_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h1);
        chk("wrap_ign_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        for (int k = 4; k <= 6; k++) begin
            drive_tick(4);
            chk("wrap_mid_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        end
        exp_q.push_back(DATA);
        drive_tick(4);
        check_frame("wrap_final");
        chk("wrap_final_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        chk("wrap_final_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);

        // SCROLL count >= ROWS, ticks on consecutive cycles clears the frame
        drive_load(3'd2, 3'd7);
        for (int k = 0; k < 7; k++) drive_tick(0);
        chk("clr_scroll_frame", 64'(bus.CC_ROWCOMP_frame_OutBUS), 64'h0);
        chk("clr_scroll_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);

        // scroll count 0 completes immediately
        exp_q.push_back(DATA);
        drive_load(3'd2, 3'd0);
        check_frame("cnt0_frame");
        chk("cnt0_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        chk("cnt0_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);

        // load and tick together in IDLE: tick ignored
        bus.CC_ROWCOMP_tick_In = 1'b1;
        drive_load(3'd2, 3'd1);
        bus.CC_ROWCOMP_tick_In = 1'b0;
        exp_q.push_back(DATA);
        check_frame("ldtick_frame");
        chk("ldtick_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h1);
        exp_q.push_back(SHIFT1);
        drive_tick(1);
        check_frame("ldtick_step");
        chk("ldtick_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);

        // abort together with tick after one step of a 3-step scroll
        drive_load(3'd2, 3'd3);
        drive_tick(2);
        bus.CC_ROWCOMP_abort_In = 1'b1;
        drive_tick(0);
        bus.CC_ROWCOMP_abort_In = 1'b0;
        exp_q.push_back(SHIFT1);
        check_frame("abort_frame");
        chk("abort_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);
        chk("abort_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);
        chk("abort_state", 64'(bus.stateDbg), 64'(ST_IDLE));
        @(negedge clk);
        chk("abort_done_late", 64'(bus.CC_ROWCOMP_done_Out), 64'h0);

        // abort in IDLE is ignored by a following tick-free load
        bus.CC_ROWCOMP_abort_In = 1'b1;
        exp_q.push_back(WALL_F);
        drive_load(3'd3, '0);
        bus.CC_ROWCOMP_abort_In = 1'b0;
        check_frame("idle_abort_load");

        // asynchronous reset in the middle of a scroll
        drive_load(3'd5, 3'd4);
        drive_tick(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_frame", 64'(bus.CC_ROWCOMP_frame_OutBUS), 64'h0);
        chk("arst_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);
        chk("arst_state", 64'(bus.stateDbg), 64'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('0);
        drive_load(3'd0, '0);
        check_frame("post_rst_clear");
        chk("post_rst_done", 64'(bus.CC_ROWCOMP_done_Out), 64'h1);
        chk("post_rst_busy", 64'(bus.CC_ROWCOMP_busy_Out), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cc_row_compositor.md
# cc_row_compositor

Registered, parametrised row-frame compositor for the LED-matrix playfield. It holds a frame of ROWS rows of WIDTH bits and, on command, loads it as one of the following:
- blank;
- pass-through of the input rows;
- a fixed wall or invader-sprite pattern;
- the input rows scrolled down by a programmable number of rows, one row per tick, with optional wrap-around.

It sits between the game-logic row registers and the matrix scan driver, and supplies the animated descent of the invader block.

## Interface
- ROWS, default 7: number of rows in the frame (≥2).
- WIDTH, default 8: bits per row (≥8).
- CW, default $clog2(ROWS+1): width of the shift-count input.
- CC_ROWCOMP_CLOCK_50  in  1: system clock; all state updates on the rising edge.
- CC_ROWCOMP_RESET_InLow  in  1: asynchronous, active-low reset.
- CC_ROWCOMP_mode_InBUS  in  3: frame mode, sampled only with load.
- CC_ROWCOMP_load_In  in  1: single-cycle command strobe.
- CC_ROWCOMP_tick_In  in  1: scroll-step strobe from the prescaler.
- CC_ROWCOMP_abort_In  in  1: cancels an active scroll.
- CC_ROWCOMP_shiftCount_InBUS  in  CW: number of scroll steps, sampled with load.
- CC_ROWCOMP_data_InBUS  in  ROWS*WIDTH: input frame; row r is bits [r*WIDTH +: WIDTH]; row ROWS-1 is the top row.
- CC_ROWCOMP_frame_OutBUS  out  ROWS*WIDTH: registered frame, same packing as the input.
- CC_ROWCOMP_busy_Out  out  1: high while scrolling.
- CC_ROWCOMP_done_Out  out  1: one-cycle pulse when a command completes.

## Operation
- Mode encoding:
  - 0 CLEAR: all rows zero.
  - 1 PASS: frame = data.
  - 2 SCROLL: frame = data, then shifted down, top row filled with zero.
  - 3 WALL: top 4 rows = 8'hF0, all other rows zero.
  - 4 SPRITE: rows from the top = 42,3C,3C,42,66,00,00 (hex).
  - 5 SCROLL_WRAP: as SCROLL, but row 0 wraps into the top row.
  - 6 and 7: treated as SPRITE.
- Pattern placement: patterns are 8 bits wide and placed in bits [7:0] of each row; bits above 7 are zero. Pattern rows are indexed from the top; rows beyond the pattern length are zero.
- States:
  - IDLE: waiting for a command.
  - SCROLL: stepping; remaining-step counter is loaded with shiftCount.
- IDLE with load high:
  - Frame is written per mode on the next edge.
  - Non-scroll modes: done pulses on the same edge; state stays IDLE.
  - Scroll modes with shiftCount=0: frame = data, done pulses, state stays IDLE.
  - Scroll modes with shiftCount>0: frame = data, go to SCROLL, busy=1.
- SCROLL, on each tick:
  - Row r ← row r+1 for r<ROWS-1.
  - Top row ← 0 (SCROLL) or old row 0 (SCROLL_WRAP).
  - Remaining-step counter decrements.
  - The step that brings the counter to 0 also returns the state to IDLE, clears busy and pulses done, all on the same edge.
- SCROLL, abort high: go to IDLE, frame holds its current value, busy drops, no done. Abort is ignored in IDLE.
- Load during SCROLL is ignored; the command is not queued.
- Shift counts ≥ ROWS are legal. Non-wrap scrolling clears the frame; wrap scrolling by ROWS restores the original frame.

## Timing
- Reset (asynchronous, any state): frame = 0, busy = 0, done = 0, state = IDLE, counter = 0. Any scroll in progress is lost.
- Load-to-frame latency: 1 cycle.
- A scroll of N steps finishes on the edge of the Nth accepted tick. Ticks that arrive without the tick strobe high contribute nothing; there is no timeout.
- Tick and load high together in IDLE: load is taken, tick is ignored.
- Abort and tick high together in SCROLL: abort wins, and no shift happens.
- done is high for exactly one cycle per completed command. Back-to-back loads in IDLE each produce their own done pulse.
- Outputs come straight from registers; there is no combinational input-to-output path.

## Structure
- Package cc_rowcomp_pkg holds:
  - the mode enum (CLEAR, PASS, SCROLL, WALL, SPRITE, SCROLL_WRAP);
  - the state enum (IDLE, SCROLL);
  - the WALL and SPRITE pattern constants, each as an array of 8-bit rows.
- One sub-module, cc_rowcomp_shifter: a combinational one-row down-shift of the frame, with a wrap select and parameters ROWS and WIDTH.
- The top level holds the FSM, the remaining-step counter, the frame register and the pattern mux.

## Test plan
- Reset with ROWS=7, WIDTH=8, then PASS load of data 0x01..0x07 (row 0..row 6): frame equals the input exactly one cycle after load; done pulses once; busy stays 0.
- SPRITE load, then mode 7 load: both give rows top→bottom 42,3C,3C,42,66,00,00; WALL gives F0,F0,F0,F0,00,00,00.
- SCROLL, shiftCount=2, ticks every 5 cycles: after tick 1 top row = 00 and row 5 = 07; after tick 2 rows 6,5,4 = 00,00,07; done pulses and busy falls on the tick-2 edge.
- SCROLL_WRAP, shiftCount=7: the final frame equals the input. A load issued mid-scroll is ignored and the frame is unchanged by it.
- Abort asserted together with the tick after 1 step of a 3-step scroll: frame holds the 1-step result, busy=0, no done pulse.
- Reset asserted mid-scroll, asynchronously between clock edges: outputs are zero immediately. After release, a CLEAR load pulses done with the frame at 0.
